// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr} entries.
// Flush overrides push/pop; the head is masked to a zero nop while empty.
module instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_valid,
  input  logic [31:0]              f_pc,
  input  logic [31:0]              f_instr,
  output logic                     f_ready,
  output logic                     d_valid,
  output logic [31:0]              d_pc,
  output logic [31:0]              d_instr,
  input  logic                     d_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push;
  logic          pop;

  // Readiness depends only on occupancy, so fetch never sees a path from d_ready.
  assign f_ready = (count_reg != FULL_COUNT);
  assign d_valid = (count_reg != '0);
  assign count   = count_reg;

  assign push = f_valid && f_ready && !flush;
  assign pop  = d_valid && d_ready && !flush;

  assign d_pc    = d_valid ? pc_mem[rd_ptr_reg]    : 32'h0000_0000;
  assign d_instr = d_valid ? instr_mem[rd_ptr_reg] : 32'h0000_0000;

  // Storage is never cleared; stale contents are hidden by the d_valid mask.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr_reg]    <= f_pc;
      instr_mem[wr_ptr_reg] <= f_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed vector table, hand sequences for reset and
// streaming, and random traffic checked against a queue-based reference.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          f_valid;
  logic [31:0]   f_pc;
  logic [31:0]   f_instr;
  logic          f_ready;
  logic          d_valid;
  logic [31:0]   d_pc;
  logic [31:0]   d_instr;
  logic          d_ready;
  logic          flush;
  logic [CW-1:0] count;

  int tests;
  int failures;

  logic [63:0] model_q [$];

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .f_valid (f_valid),
    .f_pc    (f_pc),
    .f_instr (f_instr),
    .f_ready (f_ready),
    .d_valid (d_valid),
    .d_pc    (d_pc),
    .d_instr (d_instr),
    .d_ready (d_ready),
    .flush   (flush),
    .count   (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        dr;
    logic        fl;
    int          exp_count;
    logic        exp_dv;
    logic [31:0] exp_pc;
    logic        exp_fr;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return ~pc ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ec, input logic edv,
                           input logic [31:0] epc, input logic [31:0] ein, input logic efr);
    check({tag, " count"},   64'(count),   64'(ec));
    check({tag, " d_valid"}, 64'(d_valid), 64'(edv));
    check({tag, " d_pc"},    64'(d_pc),    64'(epc));
    check({tag, " d_instr"}, 64'(d_instr), 64'(ein));
    check({tag, " f_ready"}, 64'(f_ready), 64'(efr));
  endtask

  task automatic check_model(input string tag);
    logic        dv;
    logic [63:0] head;
    dv   = (model_q.size() != 0);
    head = dv ? model_q[0] : 64'h0;
    check_all(tag, model_q.size(), dv, head[63:32], head[31:0], model_q.size() != DEPTH);
  endtask

  // One clock of traffic; the reference applies the queue rules to its own queue.
  task automatic model_step(input string tag, input logic fv, input logic [31:0] pc,
                            input logic dr, input logic fl);
    logic do_push;
    logic do_pop;
    f_valid = fv;
    f_pc    = pc;
    f_instr = instr_of(pc);
    d_ready = dr;
    flush   = fl;
    do_push = fv && (model_q.size() < DEPTH) && !fl;
    do_pop  = dr && (model_q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, instr_of(pc)});
    end
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    f_valid = 1'b0;
    d_ready = 1'b0;
    flush   = 1'b0;
    reset   = 1'b1;
    #2;
    reset   = 1'b0;
    model_q.delete();
  endtask

  task automatic add_vec(input logic fv, input logic [31:0] pc, input logic dr, input logic fl,
                         input int ec, input logic edv, input logic [31:0] epc, input logic efr);
    vec_t v;
    v.fv = fv; v.pc = pc; v.dr = dr; v.fl = fl;
    v.exp_count = ec; v.exp_dv = edv; v.exp_pc = epc; v.exp_fr = efr;
    vecs.push_back(v);
  endtask

  initial begin
    int pushes;
    int budget;
    logic [31:0] pc;
    tests    = 0;
    failures = 0;
    reset    = 1'b0;
    f_valid  = 1'b0;
    f_pc     = '0;
    f_instr  = '0;
    d_ready  = 1'b0;
    flush    = 1'b0;

    // Fill/drain, empty pop, overfill
    add_vec(1, 32'h3000, 0, 0, 1, 1, 32'h3000, 1);
    add_vec(1, 32'h3004, 0, 0, 2, 1, 32'h3000, 1);
    add_vec(1, 32'h3008, 0, 0, 3, 1, 32'h3000, 1);
    add_vec(1, 32'h300c, 0, 0, 4, 1, 32'h3000, 0);
    add_vec(1, 32'h3010, 0, 0, 4, 1, 32'h3000, 0);
    add_vec(0, 32'h0,    1, 0, 3, 1, 32'h3004, 1);
    add_vec(0, 32'h0,    1, 0, 2, 1, 32'h3008, 1);
    add_vec(0, 32'h0,    1, 0, 1, 1, 32'h300c, 1);
    add_vec(0, 32'h0,    1, 0, 0, 0, 32'h0,    1);
    add_vec(0, 32'h0,    1, 0, 0, 0, 32'h0,    1);
    // Flush priority at count 3
    add_vec(1, 32'h3100, 0, 0, 1, 1, 32'h3100, 1);
    add_vec(1, 32'h3104, 0, 0, 2, 1, 32'h3100, 1);
    add_vec(1, 32'h3108, 0, 0, 3, 1, 32'h3100, 1);
    add_vec(1, 32'h310c, 1, 1, 0, 0, 32'h0,    1);
    add_vec(1, 32'h4000, 0, 0, 1, 1, 32'h4000, 1);
    add_vec(0, 32'h0,    1, 0, 0, 0, 32'h0,    1);
    // Pop from full: first edge pops only, next edge pushes and pops
    add_vec(1, 32'h3200, 0, 0, 1, 1, 32'h3200, 1);
    add_vec(1, 32'h3204, 0, 0, 2, 1, 32'h3200, 1);
    add_vec(1, 32'h3208, 0, 0, 3, 1, 32'h3200, 1);
    add_vec(1, 32'h320c, 0, 0, 4, 1, 32'h3200, 0);
    add_vec(1, 32'h3210, 1, 0, 3, 1, 32'h3204, 1);
    add_vec(1, 32'h3214, 1, 0, 3, 1, 32'h3208, 1);
    add_vec(0, 32'h0,    1, 0, 2, 1, 32'h320c, 1);
    add_vec(0, 32'h0,    1, 0, 1, 1, 32'h3214, 1);
    add_vec(0, 32'h0,    1, 0, 0, 0, 32'h0,    1);

    // Reset asserted from time 2, held across the first edge with traffic offered
    #2;
    reset = 1'b1;
    #1;
    check_all("reset_async", 0, 0, 32'h0, 32'h0, 1);
    f_valid = 1'b1;
    f_pc    = 32'h5000;
    f_instr = instr_of(32'h5000);
    d_ready = 1'b1;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_held", 0, 0, 32'h0, 32'h0, 1);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      f_valid = vecs[i].fv;
      f_pc    = vecs[i].pc;
      f_instr = instr_of(vecs[i].pc);
      d_ready = vecs[i].dr;
      flush   = vecs[i].fl;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_dv, vecs[i].exp_pc,
                vecs[i].exp_dv ? instr_of(vecs[i].exp_pc) : 32'h0, vecs[i].exp_fr);
    end

    // Streaming: head always the entry pushed on the previous edge
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pc      = 32'h3000 + 32'(4 * i);
      f_valid = 1'b1;
      f_pc    = pc;
      f_instr = instr_of(pc);
      d_ready = 1'b1;
      flush   = 1'b0;
      @(posedge clk);
      #1;
      check_all($sformatf("stream%0d", i), 1, 1, pc, instr_of(pc), 1);
    end

    // Async reset mid-cycle at count 2
    do_reset();
    model_step("pre_rst0", 1, 32'h3300, 0, 0);
    model_step("pre_rst1", 1, 32'h3304, 0, 0);
    #3;
    f_valid = 1'b1;
    f_pc    = 32'h3308;
    f_instr = instr_of(32'h3308);
    reset   = 1'b1;
    #1;
    check_all("mid_reset", 0, 0, 32'h0, 32'h0, 1);
    @(posedge clk);
    #1;
    check_all("mid_reset_held", 0, 0, 32'h0, 32'h0, 1);
    do_reset();
    model_step("post_rst", 0, 32'h0, 1, 0);

    // Wrap-around: ten pushes with pops keeping occupancy around 2..3
    do_reset();
    pushes = 0;
    budget = 0;
    while ((pushes < 10 || model_q.size() != 0) && budget < 40) begin
      logic fv;
      logic dr;
      fv = (pushes < 10);
      dr = (model_q.size() >= 2) || (pushes >= 10);
      if (fv && model_q.size() < DEPTH) pushes++;
      model_step($sformatf("wrap%0d", budget), fv, 32'h3000 + 32'(4 * (fv ? pushes - 1 : 0)), dr, 0);
      budget++;
    end
    check("wrap_drained", 64'(budget < 40), 64'(1));

    // Random traffic against the reference queue
    do_reset();
    for (int i = 0; i < 400; i++) begin
      model_step($sformatf("rand%0d", i), $urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
